// File: rtl/codec_pkg.sv
// Shared definitions for the coefficient scan/quantize path.
// Contents:
//   state_t          scan controller states
//   BLOCK_8X8/16X16  block_mode encodings
//   N_COEFF_8/16     coefficients per block
//   shift_factor()   position-dependent quantizer shift (also used by the decode side)
package codec_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic BLOCK_8X8   = 1'b0;
    localparam logic BLOCK_16X16 = 1'b1;

    localparam int N_COEFF_8  = 64;
    localparam int N_COEFF_16 = 256;

    // p = row + col of the coefficient; higher frequencies get a coarser step.
    function automatic logic [2:0] shift_factor(input logic q, input logic mode, input logic [4:0] p);
        logic [2:0] s;
        if (!q) begin
            if (mode == BLOCK_8X8) s = (p <= 5'd6) ? 3'd3 : (p <= 5'd10) ? 3'd4 : 3'd5;
            else                   s = (p <= 5'd18) ? 3'd4 : 3'd5;
        end else begin
            if (mode == BLOCK_8X8) s = (p <= 5'd3) ? 3'd3 : (p <= 5'd6) ? 3'd4 : (p <= 5'd11) ? 3'd5 : 3'd6;
            else                   s = (p <= 5'd5) ? 3'd4 : (p <= 5'd20) ? 3'd5 : 3'd6;
        end
        return s;
    endfunction

endpackage

// File: rtl/coeff_quant_scan_zigzag.sv
// zigzag_counter: walks an 8x8 or 16x16 block in zig-zag order.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   init_i          load (0,0) and sample block_mode_i
//   block_mode_i    0 = 8x8 (down-first), 1 = 16x16 (right-first)
//   advance_i       step to the next scan position
//   row_o, col_o    current position
module zigzag_counter
    import codec_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       init_i,
    input  logic       block_mode_i,
    input  logic       advance_i,
    output logic [3:0] row_o,
    output logic [3:0] col_o
);

    // dir 1 = up-right (row-1, col+1), dir 0 = down-left (row+1, col-1)
    logic [3:0] row_q, row_d, col_q, col_d;
    logic       dir_q, dir_d, mode_q, mode_d;
    logic [3:0] max_idx;

    assign max_idx = (mode_q == BLOCK_16X16) ? 4'd15 : 4'd7;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (init_i) begin
            row_d  = 4'd0;
            col_d  = 4'd0;
            mode_d = block_mode_i;
            // Starting "up-right" at (0,0) hits the row-0 edge and steps right first.
            dir_d  = (block_mode_i == BLOCK_16X16);
        end else if (advance_i) begin
            if (dir_q) begin
                if (col_q == max_idx) begin
                    row_d = row_q + 4'd1;
                    dir_d = 1'b0;
                end else if (row_q == 4'd0) begin
                    col_d = col_q + 4'd1;
                    dir_d = 1'b0;
                end else begin
                    row_d = row_q - 4'd1;
                    col_d = col_q + 4'd1;
                end
            end else begin
                if (row_q == max_idx) begin
                    col_d = col_q + 4'd1;
                    dir_d = 1'b1;
                end else if (col_q == 4'd0) begin
                    row_d = row_q + 4'd1;
                    dir_d = 1'b1;
                end else begin
                    row_d = row_q + 4'd1;
                    col_d = col_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q  <= 4'd0;
            col_q  <= 4'd0;
            dir_q  <= 1'b0;
            mode_q <= BLOCK_8X8;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/coeff_quant_scan.sv
// coeff_quant_scan: reads one coefficient block from the packed coefficient RAM,
// quantizes each coefficient by a position-dependent shift and streams the
// results out in zig-zag order.
// Ports:
//   Clock_50, Reset            clock, asynchronous active-high reset
//   start                      begin one block (ignored unless idle)
//   block_mode, q_number       block size / quantizer table, sampled on accepted start
//   ram_address, ram_read_data RAM read port, data one cycle after address
//   coeff_data/valid/ready/last  quantized coefficient stream
//   busy, finish               block in progress / one-cycle completion pulse
module coeff_quant_scan
    import codec_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int COEFF_W = 9
) (
    input  logic                      Clock_50,
    input  logic                      Reset,
    input  logic                      start,
    input  logic                      block_mode,
    input  logic                      q_number,
    output logic [ADDR_W-1:0]         ram_address,
    input  logic [31:0]               ram_read_data,
    output logic signed [COEFF_W-1:0] coeff_data,
    output logic                      coeff_valid,
    input  logic                      coeff_ready,
    output logic                      coeff_last,
    output logic                      busy,
    output logic                      finish
);

    localparam int QW = 17;
    localparam logic signed [QW-1:0] SAT_MAX = QW'((1 << (COEFF_W - 1)) - 1);
    localparam logic signed [QW-1:0] SAT_MIN = -SAT_MAX - QW'(1);

    // Divide by 2^s rounding toward zero.
    function automatic logic signed [QW-1:0] trunc_shift(input logic signed [15:0] v, input logic [2:0] s);
        logic signed [QW-1:0] x;
        x = QW'(v);
        if (v[15]) x = x + (QW'(1) << s) - QW'(1);
        return x >>> s;
    endfunction

    function automatic logic signed [COEFF_W-1:0] sat_coeff(input logic signed [QW-1:0] v);
        if (v > SAT_MAX) return COEFF_W'(SAT_MAX);
        if (v < SAT_MIN) return COEFF_W'(SAT_MIN);
        return COEFF_W'(v);
    endfunction

    state_t state_q, state_d;
    logic [7:0] idx_q, idx_d, last_idx;
    logic       mode_q, qsel_q;
    logic       accept, issue, push, pop;

    logic [3:0] row_p0, col_p0;
    logic [7:0] addr_p0;
    logic [2:0] occ_p0;

    logic       vld_p1_q, last_p1_q;
    logic [3:0] row_p1_q, col_p1_q;

    logic signed [15:0]        sample_p2;
    logic [4:0]                pos_sum_p2;
    logic signed [COEFF_W-1:0] quant_p2;

    logic signed [COEFF_W-1:0] fifo_data_q [2];
    logic [1:0] fifo_last_q;
    logic [1:0] cnt_q, cnt_d;
    logic       wr_ptr_q, rd_ptr_q;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_idx = (mode_q == BLOCK_16X16) ? 8'(N_COEFF_16 - 1) : 8'(N_COEFF_8 - 1);

    // ---- stage 0: scan position and RAM address ----
    zigzag_counter u_zigzag (
        .clk_i        (Clock_50),
        .rst_i        (Reset),
        .init_i       (accept),
        .block_mode_i (block_mode),
        .advance_i    (issue),
        .row_o        (row_p0),
        .col_o        (col_p0)
    );

    // Two vertically adjacent rows share a word; columns are word-strided.
    assign addr_p0 = (mode_q == BLOCK_16X16) ? ({1'b0, col_p0, 3'b000} + {5'b0, row_p0[3:1]})
                                             : ({2'b00, col_p0, 2'b00} + {5'b0, row_p0[3:1]});
    assign ram_address = ADDR_W'(addr_p0);

    // Occupancy the FIFO will have after this cycle's pop and the in-flight push;
    // a new read only goes out if its result is guaranteed a slot.
    assign occ_p0 = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, vld_p1_q};
    assign issue  = (state_q == S_SCAN) && (occ_p0 < 3'd2);

    // ---- stage 1: RAM data returns; position travels alongside ----
    always_ff @(posedge Clock_50) begin
        if (issue) begin
            row_p1_q  <= row_p0;
            col_p1_q  <= col_p0;
            last_p1_q <= (idx_q == last_idx);
        end
    end

    // ---- stage 2: half-select, quantize, saturate into the output FIFO ----
    assign sample_p2  = row_p1_q[0] ? ram_read_data[15:0] : ram_read_data[31:16];
    assign pos_sum_p2 = {1'b0, row_p1_q} + {1'b0, col_p1_q};
    assign quant_p2   = sat_coeff(trunc_shift(sample_p2, shift_factor(qsel_q, mode_q, pos_sum_p2)));
    assign push       = vld_p1_q;

    always_ff @(posedge Clock_50) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= quant_p2;
            fifo_last_q[wr_ptr_q] <= last_p1_q;
        end
    end

    assign coeff_valid = (cnt_q != 2'd0);
    assign coeff_data  = coeff_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign coeff_last  = coeff_valid & fifo_last_q[rd_ptr_q];
    assign pop         = coeff_valid & coeff_ready;
    assign cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    idx_d   = 8'd0;
                end
            end
            S_SCAN: begin
                if (issue) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == last_idx) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (pop && coeff_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'd0;
            mode_q   <= BLOCK_8X8;
            qsel_q   <= 1'b0;
            vld_p1_q <= 1'b0;
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            if (accept) begin
                mode_q <= block_mode;
                qsel_q <= q_number;
            end
            vld_p1_q <= issue;
            cnt_q    <= cnt_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign finish = (state_q == S_DONE);

endmodule

// File: tb/tb_coeff_quant_scan.sv
module tb_coeff_quant_scan;

    logic              Clock_50 = 1'b0;
    logic              Reset;
    logic              start;
    logic              block_mode;
    logic              q_number;
    logic [7:0]        ram_address;
    logic [31:0]       ram_read_data;
    logic signed [8:0] coeff_data;
    logic              coeff_valid;
    logic              coeff_ready;
    logic              coeff_last;
    logic              busy;
    logic              finish;

    coeff_quant_scan #(.ADDR_W(8), .COEFF_W(9)) dut (
        .Clock_50      (Clock_50),
        .Reset         (Reset),
        .start         (start),
        .block_mode    (block_mode),
        .q_number      (q_number),
        .ram_address   (ram_address),
        .ram_read_data (ram_read_data),
        .coeff_data    (coeff_data),
        .coeff_valid   (coeff_valid),
        .coeff_ready   (coeff_ready),
        .coeff_last    (coeff_last),
        .busy          (busy),
        .finish        (finish)
    );

    always #5 Clock_50 = ~Clock_50;

    // Coefficient RAM with registered read address.
    logic [31:0] mem [0:255];
    always @(posedge Clock_50) ram_read_data <= mem[ram_address];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int exp_q[$];

    function automatic int ref_shift(input bit q, input bit m, input int p);
        if (!q && !m) return (p <= 6) ? 3 : (p <= 10) ? 4 : 5;
        if (!q &&  m) return (p <= 18) ? 4 : 5;
        if ( q && !m) return (p <= 3) ? 3 : (p <= 6) ? 4 : (p <= 11) ? 5 : 6;
        return (p <= 5) ? 4 : (p <= 20) ? 5 : 6;
    endfunction

    function automatic int ref_coeff(input bit m, input bit q, input int r, input int c);
        int n, v, res;
        logic [31:0] w;
        logic signed [15:0] h;
        n = m ? 16 : 8;
        w = mem[(r / 2) + c * (n / 2)];
        h = (r % 2 == 1) ? w[15:0] : w[31:16];
        v = h;
        res = v / (1 << ref_shift(q, m, r + c));
        if (res > 255) res = 255;
        if (res < -256) res = -256;
        return res;
    endfunction

    // Zig-zag as anti-diagonal sweeps with alternating row order.
    task automatic build_expected(input bit m, input bit q);
        int n;
        bit asc;
        exp_q.delete();
        n = m ? 16 : 8;
        for (int d = 0; d <= 2 * n - 2; d++) begin
            asc = m ? (d % 2 == 1) : (d % 2 == 0);
            for (int i = 0; i < n; i++) begin
                int r, c;
                r = asc ? i : n - 1 - i;
                c = d - r;
                if (c >= 0 && c < n) exp_q.push_back(ref_coeff(m, q, r, c));
            end
        end
    endtask

    function automatic logic [15:0] rand_half();
        if ($urandom_range(3) == 0) return 16'($urandom);
        return 16'($urandom_range(8191) - 4096);
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = {rand_half(), rand_half()};
    endtask

    // ---------------- block driver / monitor ----------------
    int first_valid, finish_k, finishes, n_acc, n_last;
    int addr_log [1:4];
    int first_vals [0:1];

    task automatic run_block(input bit m, input bit q, input int rdy_pct, input int abort_after, input bit poke);
        int n, held_d, held_l;
        bit holding, done;
        n = m ? 256 : 64;
        build_expected(m, q);
        n_acc = 0; n_last = 0; holding = 0; done = 0;
        first_valid = -1; finish_k = -1; finishes = 0;
        held_d = 0; held_l = 0;
        block_mode = m; q_number = q; start = 1'b1; coeff_ready = 1'b0;
        @(posedge Clock_50); #1;
        for (int k = 1; k <= n * 20 + 50 && !done; k++) begin
            start = 1'b0;
            if (k <= 4) addr_log[k] = int'(ram_address);
            if (coeff_valid && first_valid < 0) first_valid = k;
            if (holding) begin
                check_eq("hold_valid", int'(coeff_valid), 1);
                check_eq("hold_data", int'(coeff_data), held_d);
                check_eq("hold_last", int'(coeff_last), held_l);
            end
            if (finish) begin
                finishes++;
                finish_k = k;
                check_eq("accepts_at_finish", n_acc, n);
                done = 1;
                if (poke) start = 1'b1;   // lands on the finish cycle
            end
            if (poke && k == 10) begin
                check_eq("busy_mid_block", int'(busy), 1);
                start = 1'b1;
            end
            coeff_ready = ($urandom_range(99) < rdy_pct);
            if (coeff_valid && coeff_ready) begin
                if (n_acc < n) begin
                    check_eq("coeff_data", int'(coeff_data), exp_q[n_acc]);
                    check_eq("coeff_last", int'(coeff_last), (n_acc == n - 1) ? 1 : 0);
                end else begin
                    check_eq("extra_accept", n_acc, n - 1);
                end
                if (coeff_last) n_last++;
                if (n_acc < 2) first_vals[n_acc] = int'(coeff_data);
                n_acc++;
            end
            holding = coeff_valid && !coeff_ready;
            held_d  = int'(coeff_data);
            held_l  = int'(coeff_last);
            if (abort_after > 0 && n_acc == abort_after) done = 1;
            @(posedge Clock_50); #1;
        end
        start = 1'b0;
        coeff_ready = 1'b0;
        if (!done) check_eq("block_timeout", 0, 1);
        if (abort_after == 0) begin
            check_eq("idle_after_finish", int'(busy), 0);
            repeat (4) begin
                if (finish) finishes++;
                check_eq("no_restart", int'(busy), 0);
                @(posedge Clock_50); #1;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_addr"},   int'(ram_address), 0);
        check_eq({tag, "_data"},   int'(coeff_data), 0);
        check_eq({tag, "_valid"},  int'(coeff_valid), 0);
        check_eq({tag, "_last"},   int'(coeff_last), 0);
        check_eq({tag, "_busy"},   int'(busy), 0);
        check_eq({tag, "_finish"}, int'(finish), 0);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; block_mode = 1'b0; q_number = 1'b0; coeff_ready = 1'b0;
        fill_mem();
        repeat (3) @(posedge Clock_50);
        #1;
        check_reset_values("reset");
        Reset = 1'b0;
        @(posedge Clock_50); #1;

        // 8x8 q=0, first word gives +8 / -8, full rate.
        fill_mem();
        mem[0] = {16'h0040, 16'hFFC0};
        run_block(1'b0, 1'b0, 100, 0, 1'b0);
        check_eq("t1_first_valid_cycle", first_valid, 3);
        check_eq("t1_first", first_vals[0], 8);
        check_eq("t1_second", first_vals[1], -8);
        check_eq("t1_finish_cycle", finish_k, 64 + 3);
        check_eq("t1_finishes", finishes, 1);

        // Saturation and truncation toward zero.
        mem[0] = {16'h7FFF, 16'hFFF7};
        run_block(1'b0, 1'b0, 100, 0, 1'b0);
        check_eq("t2_sat", first_vals[0], 255);
        check_eq("t2_trunc", first_vals[1], -1);

        // 16x16 q=1: address order and last flag.
        fill_mem();
        run_block(1'b1, 1'b1, 100, 0, 1'b0);
        check_eq("t3_addr1", addr_log[1], 0);
        check_eq("t3_addr2", addr_log[2], 8);
        check_eq("t3_addr3", addr_log[3], 0);
        check_eq("t3_addr4", addr_log[4], 1);
        check_eq("t3_accepts", n_acc, 256);
        check_eq("t3_last_count", n_last, 1);
        check_eq("t3_finish_cycle", finish_k, 256 + 3);

        // Random backpressure over both block sizes and tables.
        for (int t = 0; t < 4; t++) begin
            fill_mem();
            run_block(t[1], t[0], 50, 0, 1'b0);
            check_eq("t4_accepts", n_acc, t[1] ? 256 : 64);
            check_eq("t4_last_count", n_last, 1);
            check_eq("t4_finishes", finishes, 1);
        end

        // Reset mid-block, then a fresh block.
        fill_mem();
        run_block(1'b0, 1'b1, 100, 20, 1'b0);
        Reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(posedge Clock_50); #1;
        Reset = 1'b0;
        finishes = 0;
        repeat (5) begin
            if (finish) finishes++;
            @(posedge Clock_50); #1;
        end
        check_eq("t5_no_finish_after_abort", finishes, 0);
        run_block(1'b0, 1'b1, 100, 0, 1'b0);
        check_eq("t5_first_valid_cycle", first_valid, 3);
        check_eq("t5_accepts", n_acc, 64);
        check_eq("t5_finishes", finishes, 1);

        // Start pulses while busy and on the finish cycle are ignored.
        fill_mem();
        run_block(1'b1, 1'b0, 70, 0, 1'b1);
        check_eq("t6_accepts", n_acc, 256);
        check_eq("t6_finishes", finishes, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
